// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory addressing and the IF/ID register,
// with stall hold, EX/ID redirects and program-exit (halt word) handling.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect_id,
    input  logic [15:0] redirect_id_pc,
    input  logic        redirect_ex,
    input  logic [15:0] redirect_ex_pc,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_plus1,
    output logic        ifid_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HALTPEND = 2'd1,
        HALTED   = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_plus1;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: 16'h0000, pc: 16'h0000, pc_plus1: 16'h0000, valid: 1'b0};

    // Saturating increment so the fetch counter sticks at its maximum.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    state_t      state_r;
    logic [15:0] pc_r;
    ifid_t       ifid_r;
    logic        halted_r;
    logic [15:0] count_r;

    logic        redirect_s;
    logic [15:0] redirect_pc_s;
    logic [15:0] pc_inc_s;
    logic        is_halt_s;
    ifid_t       capture_s;

    // Redirect arbitration (EX beats ID) and the candidate IF/ID capture.
    always_comb begin
        redirect_s    = redirect_ex | redirect_id;
        redirect_pc_s = redirect_id_pc;
        if (redirect_ex) begin
            redirect_pc_s = redirect_ex_pc;
        end else begin
            redirect_pc_s = redirect_id_pc;
        end
        pc_inc_s           = pc_r + 16'd1;
        is_halt_s          = (imem_data == HALT_WORD);
        capture_s.instr    = imem_data;
        capture_s.pc       = pc_r;
        capture_s.pc_plus1 = pc_inc_s;
        capture_s.valid    = 1'b1;
    end

    // Fetch state machine: PC, IF/ID register, halt flag and fetch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= RUN;
            pc_r     <= RESET_PC;
            ifid_r   <= IFID_BUBBLE;
            halted_r <= 1'b0;
            count_r  <= 16'h0000;
        end else begin
            case (state_r)
                RUN: begin
                    if (redirect_s) begin
                        pc_r   <= redirect_pc_s;
                        ifid_r <= IFID_BUBBLE;
                    end else if (stall) begin
                        pc_r   <= pc_r;
                        ifid_r <= ifid_r;
                    end else begin
                        ifid_r  <= capture_s;
                        count_r <= sat_inc(count_r);
                        // The halt word parks the PC so nothing past it is fetched.
                        if (is_halt_s) begin
                            state_r <= HALTPEND;
                        end else begin
                            pc_r <= pc_inc_s;
                        end
                    end
                end
                HALTPEND: begin
                    if (redirect_s) begin
                        pc_r    <= redirect_pc_s;
                        ifid_r  <= IFID_BUBBLE;
                        state_r <= RUN;
                    end else if (stall) begin
                        ifid_r <= ifid_r;
                    end else begin
                        ifid_r   <= IFID_BUBBLE;
                        halted_r <= 1'b1;
                        state_r  <= HALTED;
                    end
                end
                HALTED: begin
                    state_r <= HALTED;
                end
                default: begin
                    state_r <= RUN;
                    ifid_r  <= IFID_BUBBLE;
                end
            endcase
        end
    end

    assign imem_addr     = pc_r;
    assign ifid_instr    = ifid_r.instr;
    assign ifid_pc       = ifid_r.pc;
    assign ifid_pc_plus1 = ifid_r.pc_plus1;
    assign ifid_valid    = ifid_r.valid;
    assign halted        = halted_r;
    assign fetch_count   = count_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID state is queued when each step is
// driven and popped for comparison one clock edge later.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall = 1'b0;
    logic        redirect_id = 1'b0;
    logic [15:0] redirect_id_pc = 16'h0000;
    logic        redirect_ex = 1'b0;
    logic [15:0] redirect_ex_pc = 16'h0000;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_plus1;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:65535];

    typedef struct packed {
        logic        valid;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pc1;
        logic [15:0] addr;
        logic        halted;
        logic [15:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .redirect_id    (redirect_id),
        .redirect_id_pc (redirect_id_pc),
        .redirect_ex    (redirect_ex),
        .redirect_ex_pc (redirect_ex_pc),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus1  (ifid_pc_plus1),
        .ifid_valid     (ifid_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock step: drive inputs, queue the expected result, compare after the edge.
    task automatic cyc(input logic r, input logic s,
                       input logic rid, input logic [15:0] rid_pc,
                       input logic rex, input logic [15:0] rex_pc,
                       input logic ev, input logic [15:0] epc, input logic [15:0] einstr,
                       input logic [15:0] eaddr, input logic eh, input logic [15:0] ecnt);
        exp_t e;
        rst            = r;
        stall          = s;
        redirect_id    = rid;
        redirect_id_pc = rid_pc;
        redirect_ex    = rex;
        redirect_ex_pc = rex_pc;
        e.valid  = ev;
        e.pc     = epc;
        e.instr  = einstr;
        e.pc1    = ev ? (epc + 16'd1) : 16'h0000;
        e.addr   = eaddr;
        e.halted = eh;
        e.count  = ecnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, e.valid});
        chk("ifid_pc", ifid_pc, e.pc);
        chk("ifid_instr", ifid_instr, e.instr);
        chk("ifid_pc_plus1", ifid_pc_plus1, e.pc1);
        chk("imem_addr", imem_addr, e.addr);
        chk("halted", {15'd0, halted}, {15'd0, e.halted});
        chk("fetch_count", fetch_count, e.count);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'hA000 | (16'(i) & 16'h0FFF);
        end
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[5] = 16'hFFFF;

        //  rst stl rid rid_pc    rex rex_pc     v  pc        instr     addr      h  count
        cyc(1, 0, 0, 16'h0000, 0, 16'h0000,  0, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
        // sequential fetch with a 3-cycle stall while ifid_pc = 1
        cyc(0, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0000, 16'h1111, 16'h0001, 0, 16'd1);
        cyc(0, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0001, 16'h2222, 16'h0002, 0, 16'd2);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 16'h0000, 0, 16'h0000,  1, 16'h0001, 16'h2222, 16'h0002, 0, 16'd2);
        end
        cyc(0, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0002, 16'h3333, 16'h0003, 0, 16'd3);
        cyc(0, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0003, 16'hA003, 16'h0004, 0, 16'd4);
        // EX beats ID, and both beat stall
        cyc(0, 1, 1, 16'h0010, 1, 16'h0020,  0, 16'h0000, 16'h0000, 16'h0020, 0, 16'd4);
        cyc(0, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0020, 16'hA020, 16'h0021, 0, 16'd5);
        // ID-only redirect, then run into the halt word at address 5
        cyc(0, 0, 1, 16'h0004, 0, 16'h0000,  0, 16'h0000, 16'h0000, 16'h0004, 0, 16'd5);
        cyc(0, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0004, 16'hA004, 16'h0005, 0, 16'd6);
        cyc(0, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0005, 16'hFFFF, 16'h0005, 0, 16'd7);
        cyc(0, 1, 0, 16'h0000, 0, 16'h0000,  1, 16'h0005, 16'hFFFF, 16'h0005, 0, 16'd7);
        cyc(0, 0, 0, 16'h0000, 0, 16'h0000,  0, 16'h0000, 16'h0000, 16'h0005, 1, 16'd7);
        // HALTED ignores redirects and stall
        cyc(0, 0, 0, 16'h0000, 1, 16'h0030,  0, 16'h0000, 16'h0000, 16'h0005, 1, 16'd7);
        cyc(0, 1, 1, 16'h0040, 0, 16'h0000,  0, 16'h0000, 16'h0000, 16'h0005, 1, 16'd7);
        cyc(1, 0, 0, 16'h0000, 0, 16'h0000,  0, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
        // speculative halt cancelled by EX redirect in HALTPEND
        cyc(0, 0, 1, 16'h0005, 0, 16'h0000,  0, 16'h0000, 16'h0000, 16'h0005, 0, 16'd0);
        cyc(0, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0005, 16'hFFFF, 16'h0005, 0, 16'd1);
        cyc(0, 0, 0, 16'h0000, 1, 16'h0008,  0, 16'h0000, 16'h0000, 16'h0008, 0, 16'd1);
        cyc(0, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0008, 16'hA008, 16'h0009, 0, 16'd2);
        // PC wrap at 16'hFFFF
        cyc(0, 0, 0, 16'h0000, 1, 16'hFFFF,  0, 16'h0000, 16'h0000, 16'hFFFF, 0, 16'd2);
        cyc(0, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'hFFFF, 16'hAFFF, 16'h0000, 0, 16'd3);
        cyc(0, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0000, 16'h1111, 16'h0001, 0, 16'd4);
        // reset mid-stream overrides a simultaneous redirect
        cyc(1, 0, 0, 16'h0000, 1, 16'h0077,  0, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
        cyc(0, 0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0000, 16'h1111, 16'h0001, 0, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
